// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts one byte plus odd parity and stop out on device clock edges, checks the ack.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 4000,
  parameter int SETUP_CYCLES   = 40,
  parameter int TIMEOUT_CYCLES = 80000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic       clkps2_oe,
  output logic       dataps2_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] SETUP_LAST   = PW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SETUP, S_BITS, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t state, state_next;

  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          ps2_fall;
  logic [9:0]    shreg;
  logic          cur_bit;
  logic [3:0]    bit_idx;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] tcnt;
  logic          accept, timeout, done_set, err_set, in_frame;

  // Pads idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= clkps2;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= dataps2;
      data_sync <= data_meta;
    end
  end

  assign ps2_fall = clk_prev & ~clk_sync;

  // Request handshake: tx_start is taken only in IDLE and not in the cycle a
  // done/error pulse is shown; tx_busy stays high from the cycle after
  // acceptance until the cycle the completion pulse appears.
  assign accept   = (state == S_IDLE) & tx_start & ~tx_done & ~tx_error;
  assign in_frame = (state == S_BITS) | (state == S_ACK) | (state == S_WAIT_IDLE);
  assign timeout  = in_frame & (tcnt == TIMEOUT_LAST);
  assign err_set  = timeout | ((state == S_ACK) & ps2_fall & data_sync);
  assign done_set = (state == S_WAIT_IDLE) & ~timeout & clk_sync & data_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept) state_next = S_INHIBIT;
      S_INHIBIT:   if (phase_cnt == INHIBIT_LAST) state_next = S_SETUP;
      S_SETUP:     if (phase_cnt == SETUP_LAST) state_next = S_BITS;
      S_BITS: begin
        if (timeout)                           state_next = S_IDLE;
        else if (ps2_fall && bit_idx == 4'd9)  state_next = S_ACK;
      end
      S_ACK: begin
        if (timeout)       state_next = S_IDLE;
        else if (ps2_fall) state_next = data_sync ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (timeout || done_set) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    clkps2_oe  = 1'b0;
    dataps2_oe = 1'b0;
    tx_busy    = (state != S_IDLE);
    case (state)
      S_INHIBIT: clkps2_oe = 1'b1;
      S_SETUP: begin
        clkps2_oe  = 1'b1;
        dataps2_oe = 1'b1;
      end
      S_BITS:  dataps2_oe = ~cur_bit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      cur_bit   <= 1'b1;
      bit_idx   <= '0;
      phase_cnt <= '0;
      tcnt      <= '0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      tx_done  <= done_set;
      tx_error <= err_set;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg     <= {1'b1, ~^tx_data, tx_data};
            phase_cnt <= '0;
          end
        end
        S_INHIBIT: phase_cnt <= (phase_cnt == INHIBIT_LAST) ? '0 : phase_cnt + PW'(1);
        S_SETUP: begin
          phase_cnt <= phase_cnt + PW'(1);
          if (phase_cnt == SETUP_LAST) begin
            cur_bit <= 1'b0;
            bit_idx <= '0;
            tcnt    <= '0;
          end
        end
        default: begin
          if (in_frame && tcnt != TIMEOUT_LAST) tcnt <= tcnt + TW'(1);
          // Start bit is already on the line; each edge advances one bit LSB first.
          if (state == S_BITS && ps2_fall) begin
            cur_bit <= shreg[0];
            shreg   <= {1'b0, shreg[9:1]};
            bit_idx <= bit_idx + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example ED/LED set or FF/reset) from the FPGA to the attached keyboard over the shared open-drain PS/2 clock and data lines, then checks the device acknowledge bit. It sits next to the PS/2 receive port. While `tx_busy` is high, `tx_busy` gates that port's `enable_rcv` low so the receiver ignores the host-generated frame.

## Interface
- `INHIBIT_CYCLES`, 4000: number of clk cycles PS/2 clock is held low before the request-to-send (≥100 µs at the system clock).
- `SETUP_CYCLES`, 40: number of clk cycles data is held low with clock still low before clock is released.
- `TIMEOUT_CYCLES`, 80000: maximum clk cycles from clock release to the ack sample.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clkps2`  in  1  PS/2 clock pad level.
- `dataps2`  in  1  PS/2 data pad level.
- `clkps2_oe`  out  1  1 = pull PS/2 clock low; 0 = release.
- `dataps2_oe`  out  1  1 = pull PS/2 data low; 0 = release.
- `tx_data`  in  8  byte to send, captured on accepted `tx_start`.
- `tx_start`  in  1  one-cycle request.
- `tx_busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse: byte acknowledged and bus idle again.
- `tx_error`  out  1  one-cycle pulse: NACK or timeout.

## Operation
- `clkps2` and `dataps2` each pass through a 2-flop synchronizer. A falling edge is synchronized previous = 1 and current = 0.
- Shift register `{stop=1, parity, d7..d0}`. Parity is odd: parity = ~^tx_data.
- `dataps2_oe` = ~current bit. `clkps2_oe` is 1 only in INHIBIT and SETUP.
- States:
  - IDLE: outputs released.
    - `tx_start` = 1 → latch `tx_data`, load counter, go to INHIBIT.
  - INHIBIT: `clkps2_oe` = 1 for `INHIBIT_CYCLES` cycles → SETUP.
  - SETUP: `clkps2_oe` = 1 and `dataps2_oe` = 1 (start bit) for `SETUP_CYCLES` cycles → BITS.
    - Release clock, clear bit index, start the timeout counter.
  - BITS: on each falling edge, drive the next bit, LSB first:
    - edges 1–8: d0..d7.
    - edge 9: parity.
    - edge 10: stop (data released).
    - After edge 10 → ACK.
  - ACK: on the next falling edge (11th), sample synchronized data.
    - data = 0 → WAIT_IDLE.
    - data = 1 → `tx_error` pulse, go to IDLE.
  - WAIT_IDLE: wait until synchronized clock = 1 and data = 1 → `tx_done` pulse, go to IDLE.
- Timeout: a counter runs in BITS, ACK and WAIT_IDLE. When it reaches `TIMEOUT_CYCLES`: release both lines, pulse `tx_error`, go to IDLE.
- `tx_start` while `tx_busy` = 1 is ignored; the latched byte is unchanged.
- Counter widths are `$clog2(parameter+1)`. No wrap: counters saturate or reload on state entry.

## Timing
- Reset values: `clkps2_oe` = 0, `dataps2_oe` = 0, `tx_busy` = 0, `tx_done` = 0, `tx_error` = 0, state IDLE. All take effect immediately on `rst_n` low.
- Reset in mid-frame releases both lines asynchronously. No pulse is produced.
- `tx_start` high at rising edge T:
  - from T+1: `tx_busy` = 1 and `clkps2_oe` = 1.
  - from T+1+`INHIBIT_CYCLES`: `dataps2_oe` = 1.
  - at T+1+`INHIBIT_CYCLES`+`SETUP_CYCLES`: `clkps2_oe` = 0.
- A pad falling edge is detected 2–3 clk later. The new `dataps2_oe` value appears on the cycle after detection, which is well within the device's clock-low half period.
- `tx_done` and `tx_error` are mutually exclusive and last exactly one cycle. `tx_busy` falls in the same cycle as either pulse.
- `tx_start` in the same cycle as a `tx_done`/`tx_error` pulse is ignored. It is accepted from the following cycle (IDLE).

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz that grounds data on edge 11.
  - Data levels at edges 1–10: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `tx_done` is pulsed once and `tx_error` never fires.
- Send 0x07.
  - Expect parity bit 0 at edge 9 and data bits 1,1,1,0,0,0,0,0.
  - Send 0x00: expect parity bit 1.
- NACK: device leaves data high on edge 11.
  - `tx_error` pulses once and both `_oe` outputs are 0 in the next cycle.
- Timeout: device stops clocking after edge 4.
  - `tx_error` pulses exactly `TIMEOUT_CYCLES` after clock release and both lines are released.
- Assert `rst_n` low during BITS.
  - Both `_oe` outputs go to 0 without waiting for a clock edge.
  - A new 0xFF frame after reset completes with `tx_done`.
- Pulse `tx_start` with 0x55 while busy sending 0xF4.
  - The frame carries 0xF4 only and `tx_done` fires once.
